// File: rtl/gmii_rx_deframer.sv
// gmii_rx_deframer
// Turns the GMII receive side of an SGMII PCS into a byte stream of frame
// payloads. Preamble/SFD are stripped, the CRC-32 FCS is checked and removed,
// and each frame ends with m_tlast plus an error flag on m_tuser. Saturating
// good/bad frame counters are kept for status reporting.
//
// Stream handshake: m_tvalid qualifies m_tdata on every cycle it is high.
// There is no ready input and no backpressure; the stream follows GMII line
// rate exactly, and m_tlast/m_tuser are only meaningful while m_tvalid is high.
module gmii_rx_deframer #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1522,
  parameter int CNT_W   = 32
) (
  input  logic             userclk2,
  input  logic             reset,
  input  logic [7:0]       gmii_rxd,
  input  logic             gmii_rx_dv,
  input  logic             gmii_rx_er,
  output logic [7:0]       m_tdata,
  output logic             m_tvalid,
  output logic             m_tlast,
  output logic             m_tuser,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_bad,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } state_t;

  localparam logic [7:0]  PRE_BYTE = 8'h55;
  localparam logic [7:0]  SFD_BYTE = 8'hD5;
  localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
  localparam logic [31:0] CRC_RES  = 32'hDEBB_20E3;

  // Length counter must hold MAX_LEN+1, its saturation value.
  localparam int LEN_W = $clog2(MAX_LEN + 2);
  localparam logic [LEN_W-1:0] LEN_SAT = LEN_W'(MAX_LEN + 1);
  localparam logic [LEN_W-1:0] LEN_MIN = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  // Once five bytes are held, the oldest one is known not to be FCS.
  localparam logic [LEN_W-1:0] LEN_OUT = LEN_W'(5);

  state_t            state_q, state_d;
  logic [4:0][7:0]   dly_q, dly_d;      // [0] newest byte, [4] oldest byte
  logic [LEN_W-1:0]  len_q, len_d;
  logic [31:0]       crc_q, crc_d;
  logic              err_q, err_d;
  logic [7:0]        tdata_q, tdata_d;
  logic              tvalid_q, tvalid_d;
  logic              tlast_q, tlast_d;
  logic              tuser_q, tuser_d;
  logic [CNT_W-1:0]  ok_q, ok_d;
  logic [CNT_W-1:0]  bad_q, bad_d;
  logic              ok_inc, bad_inc, frame_bad;

  // One byte of the reflected CRC-32 (poly 0xEDB88320), LSB first.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc_in,
                                           input logic [7:0]  data);
    logic [31:0] c;
    c = crc_in;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ data[i]) c = (c >> 1) ^ 32'hEDB8_8320;
      else                c = c >> 1;
    end
    return c;
  endfunction

  // Next-state, datapath and output decode.
  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    len_d     = len_q;
    crc_d     = crc_q;
    err_d     = err_q;
    tdata_d   = tdata_q;
    tvalid_d  = 1'b0;
    tlast_d   = 1'b0;
    tuser_d   = 1'b0;
    ok_inc    = 1'b0;
    bad_inc   = 1'b0;
    frame_bad = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (gmii_rx_dv) begin
          if (gmii_rxd == PRE_BYTE) begin
            state_d = ST_PREAMBLE;
          end else if (gmii_rxd == SFD_BYTE) begin
            // Short preamble: SFD alone still opens a frame.
            state_d = ST_DATA;
            len_d   = '0;
            crc_d   = CRC_INIT;
            err_d   = 1'b0;
          end else begin
            state_d = ST_DROP;
          end
        end
      end

      ST_PREAMBLE: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
          bad_inc = 1'b1;
        end else if (gmii_rx_er) begin
          state_d = ST_DROP;
        end else if (gmii_rxd == PRE_BYTE) begin
          state_d = ST_PREAMBLE;
        end else if (gmii_rxd == SFD_BYTE) begin
          state_d = ST_DATA;
          len_d   = '0;
          crc_d   = CRC_INIT;
          err_d   = 1'b0;
        end else begin
          state_d = ST_DROP;
        end
      end

      ST_DATA: begin
        if (gmii_rx_dv) begin
          dly_d = {dly_q[3:0], gmii_rxd};
          crc_d = crc_byte(crc_q, gmii_rxd);
          if (len_q != LEN_SAT) len_d = len_q + LEN_W'(1);
          if (gmii_rx_er)       err_d = 1'b1;
          // A new byte arrived, so the oldest held byte is payload.
          if (len_q >= LEN_OUT) begin
            tvalid_d = 1'b1;
            tdata_d  = dly_q[4];
          end
        end else begin
          // End of frame: the oldest held byte is the final payload byte,
          // the four newer ones are the FCS already folded into crc_q.
          state_d   = ST_IDLE;
          frame_bad = err_q | (crc_q != CRC_RES) |
                      (len_q < LEN_MIN) | (len_q > LEN_MAX);
          if (len_q >= LEN_OUT) begin
            tvalid_d = 1'b1;
            tlast_d  = 1'b1;
            tuser_d  = frame_bad;
            tdata_d  = dly_q[4];
          end
          if (frame_bad) bad_inc = 1'b1;
          else           ok_inc  = 1'b1;
        end
      end

      ST_DROP: begin
        if (!gmii_rx_dv) begin
          state_d = ST_IDLE;
          bad_inc = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    ok_d  = ok_q;
    bad_d = bad_q;
    if (ok_inc  && (ok_q  != '1)) ok_d  = ok_q  + CNT_W'(1);
    if (bad_inc && (bad_q != '1)) bad_d = bad_q + CNT_W'(1);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge userclk2) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      dly_q    <= '0;
      len_q    <= '0;
      crc_q    <= CRC_INIT;
      err_q    <= 1'b0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      ok_q     <= '0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      len_q    <= len_d;
      crc_q    <= crc_d;
      err_q    <= err_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      ok_q     <= ok_d;
      bad_q    <= bad_d;
    end
  end

  assign m_tdata    = tdata_q;
  assign m_tvalid   = tvalid_q;
  assign m_tlast    = tlast_q;
  assign m_tuser    = tuser_q;
  assign frames_ok  = ok_q;
  assign frames_bad = bad_q;
  assign dbg_state  = state_q;

endmodule

// File: doc/gmii_rx_deframer.md
Name: gmii_rx_deframer

Overview:
- Receive-side stage fed by the SGMII PCS/PMA GMII receive outputs (gmii_rxd, gmii_rx_dv, gmii_rx_er) in the 125 MHz userclk2 domain.
- Strips preamble/SFD, checks the Ethernet FCS (CRC-32), removes the 4 FCS bytes, and emits each frame as a byte stream with last/error marking.
- Keeps saturating good/bad frame counters for status and LED debug.
- The stream has no backpressure; it tracks GMII line rate exactly.

Parameters:
- MIN_LEN, 64, minimum legal frame length in bytes, counted after SFD and including FCS.
- MAX_LEN, 1522, maximum legal frame length in bytes, same counting.
- CNT_W, 32, width of the statistics counters.

Ports:
- userclk2  input  1  125 MHz GMII clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- gmii_rxd  input  8  GMII receive data from PCS.
- gmii_rx_dv  input  1  GMII receive data valid.
- gmii_rx_er  input  1  GMII receive error.
- m_tdata  output  8  payload byte.
- m_tvalid  output  1  m_tdata is valid this cycle.
- m_tlast  output  1  last payload byte of the frame.
- m_tuser  output  1  frame error; meaningful only with m_tlast.
- frames_ok  output  CNT_W  count of good frames.
- frames_bad  output  CNT_W  count of bad or dropped frames.

Behaviour:
- Interface: one clock, userclk2. Reset is synchronous and active-high. All outputs are registered.
- Reset values: every output is 0, the FSM is in IDLE, the delay line is empty, and the CRC register is 0xFFFFFFFF.
- FSM states: IDLE, PREAMBLE, DATA, DROP.
- IDLE:
  - rx_dv=1 with rxd=0x55 goes to PREAMBLE.
  - rx_dv=1 with rxd=0xD5 goes to DATA (short preamble is legal).
  - rx_dv=1 with any other byte goes to DROP.
- PREAMBLE:
  - rxd=0x55 stays in PREAMBLE.
  - rxd=0xD5 goes to DATA.
  - Any other byte, or rx_er=1, goes to DROP.
  - rx_dv=0 goes to IDLE with frames_bad+1.
- DROP: discard bytes until rx_dv=0, then go to IDLE with frames_bad+1. No stream output is produced.
- DATA:
  - Each rx_dv=1 byte enters a 5-deep delay line and the CRC.
  - The length counter increments and saturates at MAX_LEN+1.
  - The error flag is set if rx_er=1 on any byte.
- CRC:
  - Reflected polynomial 0xEDB88320, LSB first, initialised to 0xFFFFFFFF at SFD.
  - The frame passes when the register equals the residue 0xDEBB20E3 after the last FCS byte.
- Output timing:
  - A payload byte sampled at clock edge e appears on m_tdata with m_tvalid=1 after edge e+5.
  - Payload bytes are contiguous, with no gaps inside a frame.
- End of frame (first edge in DATA sampling rx_dv=0):
  - The last payload byte is output with m_tlast=1.
  - m_tuser = rx_er seen | CRC mismatch | length<MIN_LEN | length>MAX_LEN.
  - frames_ok+1 if m_tuser=0, else frames_bad+1.
  - The FSM returns to IDLE.
- Runt frame (length ≤ 4 bytes, no payload): no stream output, frames_bad+1.
- Over-length frame: output continues for every byte, and m_tuser=1 at end.
- Back-to-back frames:
  - A new preamble is accepted in the same edge that closes the previous frame. IDLE logic is evaluated on that edge's rx_dv=0 sample, and the next cycle onward is taken as IDLE.
  - The final payload byte of the old frame is never lost or overwritten.
  - A 1-cycle IPG must work.
- Counters saturate at all-ones and never wrap.
- Reset mid-frame:
  - Outputs clear next cycle and the partial frame is discarded; no tlast is issued and counters are zeroed.
  - Bytes remaining in the frame after reset releases go to DROP if rx_dv is still 1 with a non-preamble byte.

Test Plan:
1. 7×0x55, 0xD5, 60-byte payload 0x00..0x3B, correct FCS (64-byte frame) -> 60 valid bytes 0x00..0x3B, tlast on 0x3B, tuser=0, first byte 5 edges after its GMII sample, frames_ok=1.
2. Same frame with FCS byte 0 XOR 0x01 -> 60 bytes output, tlast with tuser=1, frames_bad=1, frames_ok unchanged.
3. Good 64-byte frame with rx_er=1 on payload byte 20 -> tuser=1 at tlast; 1518-byte payload frame (length 1522) -> tuser=0; 1519-byte payload frame (length 1523) -> tuser=1.
4. Preamble 0x55,0x55,0x5A,... -> DROP, zero m_tvalid, frames_bad=1; runt SFD followed by 3 bytes -> no output, frames_bad=2.
5. Two good 64-byte frames with a 1-cycle rx_dv=0 gap -> 120 bytes, two tlasts, both tuser=0, frames_ok=2.
6. Reset asserted at payload byte 30 for 1 cycle while rx_dv stays 1 -> no tlast, counters 0, FSM in DROP; next clean frame -> frames_ok=1.
